move_select: RTL and testbench

Input-conditioning stage directly upstream of the `connectFour` game core: turns the raw column switches into clean, single-shot drop requests. Synchronises and debounces `sw`, enforces one-switch-at-a-time, and rejects moves into full columns using the game's column-full mask. Delivers accepted moves over a valid/ready handshake, and reports the currently hovered column for the display.

---
 rtl/move_select.sv | 127 ++++++++++++
 tb/tb_move_select.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_select.sv
// Column-switch conditioner: sync, debounce, one-switch rule, full-column reject, valid/ready move out.
// Latency: switch edge to move_valid/reject/hover is DEBOUNCE_CYCLES+3 clocks.
// Backpressure: move_valid/move_col held until move_ready; no new move until all switches released.
module move_select #(
    parameter int NUM_COLS        = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COL_W           = $clog2(NUM_COLS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] sw,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                move_ready,
    output logic                move_valid,
    output logic [COL_W-1:0]    move_col,
    output logic                hover_valid,
    output logic [COL_W-1:0]    hover_col,
    output logic                multi_err,
    output logic                reject
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_RELEASE,
        ERROR
    } state_t;

    state_t              state;
    logic [NUM_COLS-1:0] s1;
    logic [NUM_COLS-1:0] s2;
    logic [NUM_COLS-1:0] cand;
    logic [NUM_COLS-1:0] stable;
    logic [CNT_W-1:0]    cnt;

    logic                stable_any;
    logic                stable_one_hot;
    logic [COL_W-1:0]    stable_idx;

    always_comb begin
        stable_any     = |stable;
        stable_one_hot = stable_any && ((stable & (stable - NUM_COLS'(1))) == '0);
        stable_idx     = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (stable[i]) begin
                stable_idx = COL_W'(i);
            end
        end
    end

    // Any change in s2 restarts the count; cnt saturates once stable has been loaded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= cand;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            move_valid  <= 1'b0;
            move_col    <= '0;
            hover_valid <= 1'b0;
            hover_col   <= '0;
            multi_err   <= 1'b0;
            reject      <= 1'b0;
        end else begin
            hover_valid <= stable_one_hot;
            hover_col   <= stable_one_hot ? stable_idx : '0;
            reject      <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable_one_hot) begin
                        if (col_full[stable_idx]) begin
                            reject <= 1'b1;
                            state  <= WAIT_RELEASE;
                        end else begin
                            move_col   <= stable_idx;
                            move_valid <= 1'b1;
                            state      <= REQUEST;
                        end
                    end else if (stable_any) begin
                        multi_err <= 1'b1;
                        state     <= ERROR;
                    end
                end
                REQUEST: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        state      <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!stable_any) begin
                        state <= IDLE;
                    end
                end
                ERROR: begin
                    if (!stable_any) begin
                        multi_err <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_select.sv
// Bench for move_select: directed scenarios plus random switch traffic, checked against a
// window-based debounce model and an event scoreboard.
module tb_move_select;

    localparam int NC   = 8;
    localparam int D    = 4;
    localparam int CW   = 3;
    localparam int HIST = D + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NC-1:0] sw = '0;
    logic [NC-1:0] col_full = '0;
    logic          move_ready = 1'b0;
    logic          move_valid;
    logic [CW-1:0] move_col;
    logic          hover_valid;
    logic [CW-1:0] hover_col;
    logic          multi_err;
    logic          reject;

    always #5 clk = ~clk;

    move_select #(
        .NUM_COLS        (NC),
        .DEBOUNCE_CYCLES (D),
        .COL_W           (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .col_full    (col_full),
        .move_ready  (move_ready),
        .move_valid  (move_valid),
        .move_col    (move_col),
        .hover_valid (hover_valid),
        .hover_col   (hover_col),
        .multi_err   (multi_err),
        .reject      (reject)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    bit armed    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    // Reference model: stable takes a value once the synchronised input has shown it for D+1
    // consecutive samples; moves/rejects are predicted as events for the scoreboard.
    typedef struct packed {
        int kind;     // 0 = move, 1 = reject
        int col;
        int edge_no;
    } ev_t;

    ev_t           exp_q[$];
    logic [NC-1:0] samp[$];
    logic [NC-1:0] m_stable = '0;
    bit            m_mv, m_err, m_busy, m_rej, m_hv;
    int            m_col, m_hc;

    always @(posedge clk) begin : model
        logic [NC-1:0] old;
        bit            same;
        edge_n++;
        if (!reset) begin
            samp.delete();
            repeat (HIST) samp.push_back('0);
            m_stable = '0;
            m_mv = 0; m_col = 0; m_err = 0; m_busy = 0; m_rej = 0; m_hv = 0; m_hc = 0;
            armed = 1;
        end else if (armed) begin
            old = m_stable;
            samp.push_back(sw);
            void'(samp.pop_front());
            same = 1;
            for (int i = 1; i <= D; i++) if (samp[i] != samp[0]) same = 0;
            if (same) m_stable = samp[0];
            m_hv  = ($countones(old) == 1);
            m_hc  = m_hv ? $clog2(old) : 0;
            m_rej = 0;
            if (m_mv) begin
                if (move_ready) begin
                    m_mv   = 0;
                    m_busy = 1;
                end
            end else if (m_err) begin
                if (old == 0) m_err = 0;
            end else if (m_busy) begin
                if (old == 0) m_busy = 0;
            end else if (old != 0) begin
                if ($countones(old) > 1) begin
                    m_err = 1;
                end else if (col_full[$clog2(old)]) begin
                    m_rej  = 1;
                    m_busy = 1;
                    exp_q.push_back('{1, $clog2(old), edge_n});
                end else begin
                    m_mv  = 1;
                    m_col = $clog2(old);
                    exp_q.push_back('{0, m_col, edge_n});
                end
            end
        end
    end

    bit prev_mv = 0;

    always @(posedge clk) begin : monitor
        ev_t e;
        #1;
        if (armed) begin
            check("outputs", {move_valid, move_col, hover_valid, hover_col, multi_err, reject},
                  {m_mv, CW'(m_col), m_hv, CW'(m_hc), m_err, m_rej});
            if ((move_valid && !prev_mv) || reject) begin
                if (exp_q.size() == 0) begin
                    check("event_unexpected", {move_valid, reject}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", reject, e.kind);
                    check("event_col", reject ? hover_col : move_col, e.col);
                    check("event_edge", edge_n, e.edge_no);
                end
            end
            prev_mv = move_valid;
        end
    end

    task automatic wait_mv(input int exp_lat, input int exp_col, input string name);
        int e   = -1;
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            e++;
            if (move_valid) got = 1;
        end
        check({name, "_lat"}, got ? e : -1, exp_lat);
        check({name, "_col"}, move_col, exp_col);
    endtask

    task automatic ack();
        @(negedge clk);
        move_ready = 1'b1;
        @(negedge clk);
        move_ready = 1'b0;
        check("ack_drop", move_valid, 0);
    endtask

    task automatic release_all();
        @(negedge clk);
        sw = '0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int            e;
        bit            got;
        bit            seen;
        int            nrej;
        int            r;
        int            hold;
        logic [NC-1:0] v;

        // Reset with a switch already up, then first move.
        reset = 1'b0;
        sw    = 8'h04;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_outputs", {move_valid, move_col, hover_valid, hover_col, multi_err, reject}, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_mv(7, 2, "first_move");
        ack();
        release_all();

        // Handshake hold and single-shot behaviour.
        @(negedge clk);
        sw = 8'h08;
        wait_mv(7, 3, "hold_move");
        repeat (10) begin
            @(posedge clk);
            #1;
            check("hold_valid", {move_valid, move_col}, {1'b1, 3'd3});
        end
        ack();
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            seen |= move_valid;
        end
        check("no_rerequest", seen, 0);
        release_all();
        @(negedge clk);
        sw = 8'h01;
        wait_mv(7, 0, "after_release");
        ack();
        release_all();

        // Bounce shorter than the debounce window.
        @(negedge clk);
        sw = 8'h10;
        repeat (3) @(negedge clk);
        sw = '0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen |= hover_valid | move_valid;
        end
        check("bounce_ignored", seen, 0);
        @(negedge clk);
        sw = 8'h10;
        wait_mv(7, 4, "bounce_held");
        ack();
        release_all();

        // Multiple switches.
        @(negedge clk);
        sw = 8'h41;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen |= move_valid;
        end
        check("multi_err_set", multi_err, 1);
        check("multi_no_move", seen, 0);
        @(negedge clk);
        sw = 8'h40;
        repeat (10) @(negedge clk);
        check("multi_err_held", multi_err, 1);
        @(negedge clk);
        sw  = '0;
        e   = -1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            e++;
            if (!multi_err) got = 1;
        end
        check("multi_release_lat", got ? e : -1, 7);
        repeat (3) @(negedge clk);

        // Full column.
        @(negedge clk);
        col_full = 8'h80;
        sw       = 8'h80;
        nrej = 0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            nrej += int'(reject);
            seen |= move_valid;
        end
        check("reject_count", nrej, 1);
        check("reject_no_move", seen, 0);
        release_all();
        @(negedge clk);
        sw = 8'h20;
        wait_mv(7, 5, "after_reject");
        ack();
        release_all();
        col_full = '0;

        // Reset while a request is pending.
        @(negedge clk);
        sw = 8'h40;
        wait_mv(7, 6, "pre_reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_drops", move_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_mv(7, 6, "post_reset");
        ack();
        release_all();

        // Random traffic: bounces, multi-presses, full columns, random ready and rare resets.
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 9);
            if (r < 2) v = '0;
            else if (r < 8) v = NC'(1) << $urandom_range(0, 7);
            else v = (NC'(1) << $urandom_range(0, 7)) | (NC'(1) << $urandom_range(0, 7));
            hold = $urandom_range(1, 14);
            if ($urandom_range(0, 3) == 0) col_full = NC'($urandom);
            repeat (hold) begin
                @(negedge clk);
                sw         = v;
                move_ready = ($urandom_range(0, 2) == 0);
                reset      = ($urandom_range(0, 149) != 0);
            end
        end
        @(negedge clk);
        reset      = 1'b1;
        sw         = '0;
        move_ready = 1'b1;
        repeat (30) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
